calc_alu: RTL

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_alu_pkg.sv | 44 ++++
 rtl/calc_divider.sv | 63 ++++++
 rtl/calc_alu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/calc_alu_pkg.sv
// Shared widths, result/indicator codes, state and op encodings for the calculator ALU.
package calc_alu_pkg;

  localparam int OPND_W    = 4;
  localparam int IND_ALU_W = 11;
  localparam int C_ALU_W   = 3;
  localparam int ARIFS_W   = 4;
  localparam int DEC_SCALE = 100;

  localparam logic [C_ALU_W-1:0] C_POS = 3'd0;
  localparam logic [C_ALU_W-1:0] C_NEG = 3'd1;
  localparam logic [C_ALU_W-1:0] C_ERR = 3'd2;
  localparam logic [C_ALU_W-1:0] C_DOT = 3'd4;

  localparam logic [ARIFS_W-1:0] AR_IDLE = 4'b1111;
  localparam logic [ARIFS_W-1:0] AR_ADD  = 4'b1110;
  localparam logic [ARIFS_W-1:0] AR_SUB  = 4'b1101;
  localparam logic [ARIFS_W-1:0] AR_MUL  = 4'b1011;
  localparam logic [ARIFS_W-1:0] AR_DIV  = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_B, S_CALC, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  function automatic logic op_valid(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

  function automatic op_e op_decode(input logic [3:0] b);
    if (b[3])      return OP_DIV;
    else if (b[2]) return OP_MUL;
    else if (b[1]) return OP_SUB;
    else           return OP_ADD;
  endfunction

  function automatic logic [ARIFS_W-1:0] op_arifs(input op_e op);
    case (op)
      OP_ADD:  return AR_ADD;
      OP_SUB:  return AR_SUB;
      OP_MUL:  return AR_MUL;
      default: return AR_DIV;
    endcase
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring divider, one quotient bit per cycle; quotient shifts into the dividend register.
module calc_divider
  import calc_alu_pkg::*;
#(
  parameter int OPND    = OPND_W,
  parameter int IND_ALU = IND_ALU_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [IND_ALU-1:0] dividend_i,
  input  logic [OPND-1:0]    divisor_i,
  output logic               done_o,
  output logic [IND_ALU-1:0] quot_o
);

  localparam int CW = $clog2(IND_ALU);

  logic [IND_ALU-1:0] dq_q, dq_d;
  logic [OPND-1:0]    rem_q, rem_d, dvs_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic [OPND:0]      r_sh, diff;
  logic               ge;

  always_comb begin
    r_sh  = {rem_q, dq_q[IND_ALU-1]};
    diff  = r_sh - {1'b0, dvs_q};
    ge    = r_sh >= {1'b0, dvs_q};
    // remainder stays below the divisor, so the top bit is always clear here
    rem_d = ge ? diff[OPND-1:0] : r_sh[OPND-1:0];
    dq_d  = {dq_q[IND_ALU-2:0], ge};
  end

  // done is raised during the last step so the caller commits on that same edge
  assign done_o = run_q && (cnt_q == CW'(IND_ALU-1));
  assign quot_o = dq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q  <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      dq_q  <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_alu.sv
// Two-operand calculator ALU: add/sub in one cycle, shift-add multiply, scaled restoring divide.
module calc_alu
  import calc_alu_pkg::*;
#(
  parameter int OPND    = OPND_W,
  parameter int IND_ALU = IND_ALU_W,
  parameter int C_ALU   = C_ALU_W,
  parameter int ARIFS   = ARIFS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPND-1:0]    sw,
  input  logic [3:0]         btn_op,
  input  logic               btn_eq,
  input  logic               btn_clr,
  output logic [IND_ALU-1:0] ind_from_ALU,
  output logic [C_ALU-1:0]   c_from_ALU,
  output logic [ARIFS-1:0]   arifs,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(OPND);

  state_e             state_q;
  op_e                op_q;
  logic [OPND-1:0]    a_q, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IND_ALU-1:0] acc_q, acc_d;
  logic [IND_ALU-1:0] ind_q;
  logic [C_ALU-1:0]   c_q;
  logic [ARIFS-1:0]   arifs_q;
  logic               busy_q, done_q;

  logic               op_ok, commit;
  logic [IND_ALU-1:0] res_ind;
  logic [C_ALU-1:0]   res_c;
  logic               div_start, div_done;
  logic [IND_ALU-1:0] div_q;

  assign op_ok = op_valid(btn_op);

  // divider loads on the CALC-entry edge so its last step lands on edge IND_ALU
  assign div_start = (state_q == S_WAIT_B) && btn_eq && !btn_clr &&
                     (op_q == OP_DIV) && (sw != '0);

  calc_divider #(.OPND(OPND), .IND_ALU(IND_ALU)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .abort_i   (btn_clr),
    .dividend_i(IND_ALU'(a_q) * IND_ALU'(DEC_SCALE)),
    .divisor_i (sw),
    .done_o    (div_done),
    .quot_o    (div_q)
  );

  always_comb begin
    acc_d   = acc_q + (b_q[cnt_q] ? (IND_ALU'(a_q) << cnt_q) : '0);
    commit  = 1'b0;
    res_ind = '0;
    res_c   = C_POS;
    case (op_q)
      OP_ADD: begin
        commit  = 1'b1;
        res_ind = IND_ALU'(a_q) + IND_ALU'(b_q);
      end
      OP_SUB: begin
        commit = 1'b1;
        if (a_q >= b_q) res_ind = IND_ALU'(a_q) - IND_ALU'(b_q);
        else begin
          res_ind = IND_ALU'(b_q) - IND_ALU'(a_q);
          res_c   = C_NEG;
        end
      end
      OP_MUL: begin
        commit  = (cnt_q == CNT_W'(OPND-1));
        res_ind = acc_d;
      end
      default: begin
        if (b_q == '0) begin
          commit = 1'b1;
          res_c  = C_ERR;
        end else begin
          commit  = div_done;
          res_ind = div_q;
          res_c   = C_DOT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ind_q   <= '0;
      c_q     <= '0;
      arifs_q <= AR_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (btn_clr) begin
        state_q <= S_IDLE;
        ind_q   <= '0;
        c_q     <= '0;
        arifs_q <= AR_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (op_ok) begin
              a_q     <= sw;
              op_q    <= op_decode(btn_op);
              arifs_q <= AR_IDLE;
              state_q <= S_WAIT_B;
            end
          end
          S_WAIT_B: begin
            // execute wins over a same-cycle op press
            if (btn_eq) begin
              b_q     <= sw;
              cnt_q   <= '0;
              acc_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end else if (op_ok) begin
              op_q <= op_decode(btn_op);
            end
          end
          S_CALC: begin
            if (op_q == OP_MUL) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 1'b1;
            end
            if (commit) begin
              ind_q   <= res_ind;
              c_q     <= res_c;
              arifs_q <= op_arifs(op_q);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ind_from_ALU = ind_q;
  assign c_from_ALU   = c_q;
  assign arifs        = arifs_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
